pipe_ctrl: RTL

//  Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
//  - Merges stage stall requests into the per-stage stall vector.
//  - Runs the exception/eret flush sequence and supplies the redirect PC.
//  - Freezes the pipe on debug halt.
//  - Keeps a saturating stall-cycle counter and a sticky stall-timeout flag.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_sat_cnt.sv | 37 +++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
//   - reset polarity and zero word
//   - stall vectors: bit [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
//   - eret exception code
//   - controller state encoding
//   - redirect_pc(): picks the flush target for an exception code
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

  // A stall at stage N also holds every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FLUSH = 2'd1,
    CTRL_HALT  = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
  } stallreq_t;

  // eret returns to the saved EPC; everything else goes to the fixed vector.
  function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                               input logic [31:0] epc,
                                               input logic [31:0] vec);
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// ctrl_sat_cnt: width-parameterised saturating up-counter.
//   clk  in          clock
//   rst  in          synchronous reset (RST_ENABLE polarity), clears count
//   inc  in          count up by one unless already at MAX
//   clr  in          clear to zero; wins over inc
//   cnt  out [W-1:0] current count
module ctrl_sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q < MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) cnt_q <= '0;
    else                   cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 6-stage pipe (pc, if, id, ex, mem, wb).
//   clk            in       clock
//   rst            in       synchronous reset, active-high
//   stallreq_id/ex/mem in   per-stage stall requests
//   halt_req       in       debug halt, level-sensitive
//   excepttype_i   in  [31:0] exception code from mem, 0 = none, 0xe = eret
//   cp0_epc_i      in  [31:0] return address for eret
//   stall          out [5:0]  per-stage hold vector
//   flush          out        clear all stage registers
//   new_pc         out [31:0] redirect target, meaningful while flush=1
//   halted         out        controller is in HALT
//   stall_timeout  out        sticky: a RUN stall lasted MAX_STALL cycles
//   stall_cycles   out [31:0] saturating count of cycles with stall!=0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [15:0] MAX_STALL    = 16'd1024,
  parameter logic [31:0] EXC_VECTOR   = 32'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        halt_req,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        halted,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  // Remaining FLUSH-state cycles after the RUN cycle that took the exception.
  localparam logic [3:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  ctrl_state_e state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        timeout_q, timeout_d;

  stallreq_t   req;
  logic        any_req;
  logic [31:0] exc_target;
  logic        run_inc;
  logic [15:0] run_cnt;

  assign req        = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id};
  assign any_req    = |req;
  assign exc_target = redirect_pc(excepttype_i, cp0_epc_i, EXC_VECTOR);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    stall       = STALL_NONE;
    flush       = 1'b0;
    new_pc      = ZERO_WORD;
    halted      = 1'b0;
    run_inc     = 1'b0;

    unique case (state_q)
      CTRL_RUN: begin
        if (excepttype_i != ZERO_WORD) begin
          // Zero-latency redirect; target is latched for any FLUSH tail.
          flush    = 1'b1;
          new_pc   = exc_target;
          new_pc_d = exc_target;
          if (FLUSH_CYCLES > 1) begin
            state_d     = CTRL_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else if (halt_req) begin
          stall   = STALL_ALL;
          state_d = CTRL_HALT;
        end else begin
          run_inc = any_req;
          if      (req.mem) stall = STALL_MEM;
          else if (req.ex)  stall = STALL_EX;
          else if (req.id)  stall = STALL_ID;
        end
      end
      CTRL_FLUSH: begin
        flush  = 1'b1;
        new_pc = new_pc_q;
        if (flush_cnt_q == 4'd0) state_d     = CTRL_RUN;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      CTRL_HALT: begin
        // mem stage is frozen, so any pending exception waits for resume.
        stall  = STALL_ALL;
        halted = 1'b1;
        if (!halt_req) state_d = CTRL_RUN;
      end
      default: state_d = CTRL_RUN;
    endcase

    if (rst == RST_ENABLE) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = ZERO_WORD;
      halted = 1'b0;
    end
  end

  // Set on the cycle the run counter reaches MAX_STALL so the flag is
  // visible together with the count.
  assign timeout_d = timeout_q | (run_inc && (run_cnt >= MAX_STALL - 16'd1));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= CTRL_RUN;
      flush_cnt_q <= 4'd0;
      new_pc_q    <= ZERO_WORD;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      new_pc_q    <= new_pc_d;
      timeout_q   <= timeout_d;
    end
  end

  // Consecutive RUN stall cycles; any non-stalling cycle (or leaving RUN)
  // restarts the count.
  ctrl_sat_cnt #(.WIDTH(16), .MAX(MAX_STALL)) u_stall_run_cnt (
    .clk (clk),
    .rst (rst),
    .inc (run_inc),
    .clr (!run_inc),
    .cnt (run_cnt)
  );

  ctrl_sat_cnt #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_stall_cycles (
    .clk (clk),
    .rst (rst),
    .inc (stall != STALL_NONE),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

  assign stall_timeout = timeout_q;

endmodule
